// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: consumer end of the Execute/Memory pipeline latch.
// ALU results pass straight to a registered writeback bundle. Loads and
// stores run over a single-outstanding req/ack data-memory handshake while
// mStall freezes the EM latch and everything upstream of it.
// Optional feature macro: MEM_TIMEOUT_EN. When defined, an access that sees
// no dAck for TIMEOUT_CYCLES ACCESS cycles is aborted with a one-cycle mErr.
// When undefined, ACCESS waits indefinitely and mErr is tied low.
module mem_stage_ctrl #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int RD_W           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mFlush,
    input  logic              mRdEnable,
    input  logic              mAddrEnable,
    input  logic [DATA_W-1:0] mResult,
    input  logic [ADDR_W-1:0] mAddr,
    input  logic [RD_W-1:0]   mRd,
    output logic              mStall,
    output logic              dReq,
    output logic              dWe,
    output logic [ADDR_W-1:0] dAddr,
    output logic [DATA_W-1:0] dWData,
    input  logic              dAck,
    input  logic [DATA_W-1:0] dRData,
    output logic              wValid,
    output logic              wRdEnable,
    output logic [RD_W-1:0]   wRd,
    output logic [DATA_W-1:0] wResult,
    output logic              mErr
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic              dreq_q,    dreq_d;
    logic              dwe_q,     dwe_d;
    logic [ADDR_W-1:0] daddr_q,   daddr_d;
    logic [DATA_W-1:0] dwdata_q,  dwdata_d;
    logic              wvalid_q,  wvalid_d;
    logic              wrden_q,   wrden_d;
    logic [RD_W-1:0]   wrd_q,     wrd_d;
    logic [DATA_W-1:0] wresult_q, wresult_d;
    logic [RD_W-1:0]   rdcap_q,   rdcap_d;

    logic              mstall_s;
    logic              mem_op_s;
    logic              timeout_hit_s;
    logic              unused_s;

    // Byte offset is dropped by word alignment; the timeout depth only matters with the feature on.
    assign unused_s = ^{mAddr[1:0], (TIMEOUT_CYCLES > 0)};

    // A valid memory instruction is waiting in the EM slot.
    assign mem_op_s = !mFlush && mAddrEnable;

`ifdef MEM_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // cnt_q counts earlier ACCESS cycles without dAck, so the limit is hit in the last allowed cycle.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             merr_q, merr_d;

    // Detect the final unacknowledged ACCESS cycle; a same-cycle dAck wins.
    always_comb begin
        timeout_hit_s = (state_q == ST_ACCESS) && !dAck && (cnt_q == CNT_LIMIT);
    end

    // Wait counter: clear on issue, saturating increment while waiting, abort flag on the limit.
    always_comb begin
        cnt_d  = cnt_q;
        merr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_s) begin
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ACCESS: begin
                if (timeout_hit_s) begin
                    merr_d = 1'b1;
                end else if (!dAck && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Wait counter and abort pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= {CNT_W{1'b0}};
            merr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            merr_q <= merr_d;
        end
    end

    assign mErr = merr_q;
`else
    assign timeout_hit_s = 1'b0;
    assign mErr          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: issue a memory op from IDLE, leave ACCESS on ack or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (dAck || timeout_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall: hold the EM latch from issue until the cycle the access ends.
    always_comb begin
        mstall_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mstall_s = mem_op_s;
            end
            ST_ACCESS: begin
                mstall_s = !dAck && !timeout_hit_s;
            end
            default: begin
                mstall_s = 1'b0;
            end
        endcase
    end

    assign mStall = mstall_s;

    // Outputs: memory request fields, captured Rd and the writeback bundle for the next edge.
    always_comb begin
        dreq_d    = dreq_q;
        dwe_d     = dwe_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        wvalid_d  = 1'b0;
        wrden_d   = 1'b0;
        wrd_d     = wrd_q;
        wresult_d = wresult_q;
        rdcap_d   = rdcap_q;
        case (state_q)
            ST_IDLE: begin
                if (mFlush) begin
                    dreq_d = 1'b0;
                end else if (mAddrEnable) begin
                    dreq_d   = 1'b1;
                    dwe_d    = !mRdEnable;
                    daddr_d  = {mAddr[ADDR_W-1:2], 2'b00};
                    dwdata_d = mResult;
                    rdcap_d  = mRd;
                end else begin
                    wvalid_d  = 1'b1;
                    wrden_d   = mRdEnable;
                    wrd_d     = mRd;
                    wresult_d = mResult;
                end
            end
            ST_ACCESS: begin
                if (dAck) begin
                    dreq_d   = 1'b0;
                    wvalid_d = 1'b1;
                    if (!dwe_q) begin
                        wrden_d   = 1'b1;
                        wrd_d     = rdcap_q;
                        wresult_d = dRData;
                    end else begin
                        wresult_d = dwdata_q;
                    end
                end else if (timeout_hit_s) begin
                    dreq_d   = 1'b0;
                    wvalid_d = 1'b1;
                end else begin
                    dreq_d = 1'b1;
                end
            end
            default: begin
                dreq_d = 1'b0;
            end
        endcase
    end

    // Output and capture registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dreq_q    <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= {ADDR_W{1'b0}};
            dwdata_q  <= {DATA_W{1'b0}};
            wvalid_q  <= 1'b0;
            wrden_q   <= 1'b0;
            wrd_q     <= {RD_W{1'b0}};
            wresult_q <= {DATA_W{1'b0}};
            rdcap_q   <= {RD_W{1'b0}};
        end else begin
            dreq_q    <= dreq_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            wvalid_q  <= wvalid_d;
            wrden_q   <= wrden_d;
            wrd_q     <= wrd_d;
            wresult_q <= wresult_d;
            rdcap_q   <= rdcap_d;
        end
    end

    assign dReq      = dreq_q;
    assign dWe       = dwe_q;
    assign dAddr     = daddr_q;
    assign dWData    = dwdata_q;
    assign wValid    = wvalid_q;
    assign wRdEnable = wrden_q;
    assign wRd       = wrd_q;
    assign wResult   = wresult_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed scenarios followed by randomized
// instruction/ack traffic, checked against a transaction-level reference
// model (one pending access record plus expected writeback bundle).
// Build with MEM_TIMEOUT_EN defined to exercise the abort path (limit 4).
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mFlush = 1'b0, mRdEnable = 1'b0, mAddrEnable = 1'b0;
    logic [31:0] mResult = 32'h0, mAddr = 32'h0;
    logic [3:0]  mRd = 4'h0;
    logic        mStall, dReq, dWe, dAck = 1'b0;
    logic [31:0] dAddr, dWData, dRData = 32'h0;
    logic        wValid, wRdEnable, mErr;
    logic [3:0]  wRd;
    logic [31:0] wResult;

    mem_stage_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_W(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .mFlush(mFlush), .mRdEnable(mRdEnable),
        .mAddrEnable(mAddrEnable), .mResult(mResult), .mAddr(mAddr), .mRd(mRd),
        .mStall(mStall), .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData),
        .dAck(dAck), .dRData(dRData), .wValid(wValid), .wRdEnable(wRdEnable),
        .wRd(wRd), .wResult(wResult), .mErr(mErr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one pending access record and the expected registered outputs.
    logic        m_busy = 1'b0, m_load = 1'b0;
    logic [3:0]  m_rd = 4'h0;
    int          m_waits = 0;
    logic        exp_clear = 1'b1;
    logic        exp_dreq = 1'b0, exp_dwe = 1'b0, exp_wvalid = 1'b0, exp_wrden = 1'b0, exp_merr = 1'b0;
    logic [31:0] exp_daddr = 32'h0, exp_dwdata = 32'h0, exp_wres = 32'h0;
    logic [3:0]  exp_wrd = 4'h0;
    logic        exp_stall;
    logic        last_stall;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check stall, advance the model.
    task automatic apply_cycle(input logic rst_i, input logic flush_i, input logic rden_i,
                               input logic aen_i, input logic [31:0] res_i,
                               input logic [31:0] addr_i, input logic [3:0] rd_i,
                               input logic ack_i, input logic [31:0] rdata_i);
        bit limit;
        @(negedge clk);
        chk_eq("dReq", dReq, exp_dreq);
        chk_eq("wValid", wValid, exp_wvalid);
        chk_eq("wRdEnable", wRdEnable, exp_wrden);
        chk_eq("wRd", wRd, exp_wrd);
        chk_eq("wResult", wResult, exp_wres);
        chk_eq("mErr", mErr, exp_merr);
        if (exp_dreq || exp_clear) begin
            chk_eq("dWe", dWe, exp_dwe);
            chk_eq("dAddr", dAddr, exp_daddr);
            chk_eq("dWData", dWData, exp_dwdata);
        end
        rst = rst_i; mFlush = flush_i; mRdEnable = rden_i; mAddrEnable = aen_i;
        mResult = res_i; mAddr = addr_i; mRd = rd_i; dAck = ack_i; dRData = rdata_i;
`ifdef MEM_TIMEOUT_EN
        limit = m_busy && (m_waits == TO - 1);
`else
        limit = 1'b0;
`endif
        exp_stall = m_busy ? (!ack_i && !limit) : (!flush_i && aen_i);
        #1;
        last_stall = mStall;
        chk_eq("mStall", mStall, exp_stall);
        // Model the coming rising edge.
        exp_wvalid = 1'b0; exp_wrden = 1'b0; exp_merr = 1'b0;
        if (!rst_i) begin
            m_busy = 1'b0; m_waits = 0; exp_clear = 1'b1;
            exp_dreq = 1'b0; exp_dwe = 1'b0; exp_daddr = 32'h0; exp_dwdata = 32'h0;
            exp_wrd = 4'h0; exp_wres = 32'h0;
        end else if (!m_busy) begin
            if (!flush_i && aen_i) begin
                m_busy = 1'b1; m_load = rden_i; m_rd = rd_i; m_waits = 0; exp_clear = 1'b0;
                exp_dreq = 1'b1; exp_dwe = !rden_i;
                exp_daddr = addr_i & 32'hFFFF_FFFC; exp_dwdata = res_i;
            end else if (!flush_i) begin
                exp_wvalid = 1'b1; exp_wrden = rden_i; exp_wrd = rd_i; exp_wres = res_i;
            end
        end else if (ack_i) begin
            m_busy = 1'b0; exp_dreq = 1'b0; exp_wvalid = 1'b1;
            if (m_load) begin
                exp_wrden = 1'b1; exp_wrd = m_rd; exp_wres = rdata_i;
            end else begin
                exp_wres = exp_dwdata;
            end
        end else begin
            m_waits++;
`ifdef MEM_TIMEOUT_EN
            if (m_waits == TO) begin
                m_busy = 1'b0; exp_dreq = 1'b0; exp_wvalid = 1'b1; exp_merr = 1'b1;
            end
`endif
        end
    endtask

    // Idle filler cycle (bubble), used to observe retirements.
    task automatic bubble(input logic ack_i);
        apply_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ack_i, 32'h0);
    endtask

    initial begin
        int s;
        logic [31:0] r_res, r_addr;
        logic [3:0]  r_rd;
        logic        r_flush, r_rden, r_aen;

        // Reset: outputs checked as zero on the first cycles.
        apply_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        apply_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

        // ALU op, latency 1, no stall.
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 4'd3, 1'b0, 32'h0);
        chk_eq("t1_stall", last_stall, 1'b0);
        bubble(1'b1);
        chk_eq("t1_wvalid", wValid, 1'b1);
        chk_eq("t1_wrd", wRd, 4'd3);
        chk_eq("t1_wres", wResult, 32'h1234_5678);

        // Load with three wait cycles.
        s = 0;
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h5555_0000, 32'h0000_0106, 4'd5, 1'b0, 32'h0);
        s += last_stall;
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h5555_0000, 32'h0000_0106, 4'd5, 1'b0, 32'h0);
        s += last_stall;
        chk_eq("t2_daddr", dAddr, 32'h0000_0104);
        chk_eq("t2_dreq", dReq, 1'b1);
        chk_eq("t2_dwe", dWe, 1'b0);
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h5555_0000, 32'h0000_0106, 4'd5, 1'b0, 32'h0);
        s += last_stall;
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h5555_0000, 32'h0000_0106, 4'd5, 1'b0, 32'h0);
        s += last_stall;
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h5555_0000, 32'h0000_0106, 4'd5, 1'b1, 32'hCAFE_BABE);
        s += last_stall;
        chk_eq("t2_stall_cycles", s, 32'd4);
        bubble(1'b0);
        chk_eq("t2_wres", wResult, 32'hCAFE_BABE);
        chk_eq("t2_wrd", wRd, 4'd5);
        chk_eq("t2_wvalid", wValid, 1'b1);

        // Store acked in the first ACCESS cycle.
        apply_cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 4'd7, 1'b0, 32'h0);
        apply_cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 4'd7, 1'b1, 32'h0);
        chk_eq("t3_dwe", dWe, 1'b1);
        chk_eq("t3_dwdata", dWData, 32'hDEAD_BEEF);
        chk_eq("t3_daddr", dAddr, 32'h0000_0040);
        bubble(1'b0);
        chk_eq("t3_wvalid", wValid, 1'b1);
        chk_eq("t3_wrden", wRdEnable, 1'b0);

        // Flushed memory op: no request, no retire, no stall.
        apply_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h0000_0080, 4'd2, 1'b0, 32'h0);
        chk_eq("t4_stall", last_stall, 1'b0);
        bubble(1'b0);
        chk_eq("t4_dreq", dReq, 1'b0);
        chk_eq("t4_wvalid", wValid, 1'b0);

        // Reset during the second wait cycle, then an ALU op.
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0200, 4'd9, 1'b0, 32'h0);
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0200, 4'd9, 1'b0, 32'h0);
        apply_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0200, 4'd9, 1'b0, 32'h0);
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001, 32'h0, 4'd6, 1'b0, 32'h0);
        chk_eq("t5_dreq", dReq, 1'b0);
        chk_eq("t5_daddr", dAddr, 32'h0);
        bubble(1'b0);
        chk_eq("t5_wvalid", wValid, 1'b1);
        chk_eq("t5_wres", wResult, 32'hA5A5_0001);

`ifdef MEM_TIMEOUT_EN
        // Timeout abort after four unacknowledged ACCESS cycles.
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0300, 4'd4, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0300, 4'd4, 1'b0, 32'h0);
        end
        chk_eq("t6_stall_last", last_stall, 1'b0);
        bubble(1'b0);
        chk_eq("t6_merr", mErr, 1'b1);
        chk_eq("t6_wvalid", wValid, 1'b1);
        chk_eq("t6_dreq", dReq, 1'b0);
        // Ack on the limit cycle wins.
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0300, 4'd4, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0300, 4'd4, 1'b0, 32'h0);
        end
        apply_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0300, 4'd4, 1'b1, 32'h7777_8888);
        bubble(1'b0);
        chk_eq("t6_ack_merr", mErr, 1'b0);
        chk_eq("t6_ack_wres", wResult, 32'h7777_8888);
`endif

        // Randomized traffic against the model.
        r_flush = 1'b0; r_rden = 1'b0; r_aen = 1'b0;
        r_res = 32'h0; r_addr = 32'h0; r_rd = 4'h0;
        for (int c = 0; c < 1500; c++) begin
            logic rst_v, ack_v;
            int kind;
            rst_v = ($urandom_range(0, 79) != 0);
            if (m_busy) begin
                ack_v = ($urandom_range(0, 2) == 0);
            end else begin
                kind = $urandom_range(0, 9);
                r_flush = (kind < 2);
                r_aen   = (kind < 2) ? $urandom_range(0, 1) : (kind >= 5);
                r_rden  = (kind < 2) ? $urandom_range(0, 1) : (kind < 8);
                r_res   = $urandom;
                r_addr  = $urandom;
                r_rd    = $urandom_range(0, 15);
                ack_v   = ($urandom_range(0, 4) == 0);
            end
            apply_cycle(rst_v, r_flush, r_rden, r_aen, r_res, r_addr, r_rd, ack_v, $urandom);
        end
        bubble(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the Execute/Memory pipeline latch; sits between the EM latch outputs and the Memory/Writeback latch.
- Decodes the latched access flags and passes ALU results straight through.
- Runs data-memory loads and stores over a req/ack handshake, stalling the upstream pipeline while an access is outstanding.
- Presents a registered writeback bundle every time an instruction retires from the stage.

Parameters:
DATA_W, 32, data and result width
ADDR_W, 32, byte address width
RD_W, 4, destination register index width
TIMEOUT_CYCLES, 16, ACCESS cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low (rst==0 resets on the next rising clk)
mFlush  in  1  EM slot holds a bubble
mRdEnable  in  1  instruction writes Rd
mAddrEnable  in  1  instruction accesses data memory
mResult  in  DATA_W  ALU result / store data
mAddr  in  ADDR_W  memory byte address
mRd  in  RD_W  destination register
mStall  out  1  hold EM latch and upstream stages (combinational)
dReq  out  1  memory request
dWe  out  1  1=store, 0=load
dAddr  out  ADDR_W  word-aligned address
dWData  out  DATA_W  store data
dAck  in  1  memory completes the current request (single cycle)
dRData  in  DATA_W  load data, valid when dAck=1
wValid  out  1  writeback bundle valid (single-cycle pulse per retired instruction)
wRdEnable  out  1  register write enable
wRd  out  RD_W  register index
wResult  out  DATA_W  writeback value
mErr  out  1  access aborted (single-cycle pulse)

Behaviour:
- Reset (rst==0 at an edge): state=IDLE. All outputs are 0: dReq, dWe, dAddr, dWData, wValid, wRdEnable, wRd, wResult, mErr.
- Reset mid-ACCESS drops dReq the next cycle with no completion. The memory model must tolerate an abandoned request.
- Decode, valid only when mFlush==0:
  - mAddrEnable==0: ALU op.
  - mAddrEnable==1 and mRdEnable==1: load.
  - mAddrEnable==1 and mRdEnable==0: store.
- mFlush==1: bubble. No memory access, wValid=0 and wRdEnable=0 at the next edge. mRdEnable and mAddrEnable are ignored.
- ALU op in IDLE: next edge gives wValid=1, wRdEnable=mRdEnable, wRd=mRd, wResult=mResult. Latency 1. mStall=0.
- Memory op in IDLE: mStall=1 in the same cycle. At the edge:
  - state goes to ACCESS;
  - dReq=1, dWe=store;
  - dAddr={mAddr[ADDR_W-1:2],2'b00}; mAddr[1:0] is ignored;
  - dWData=mResult;
  - wValid=0.
  - Rd and the op type are captured internally.
- ACCESS: dReq, dWe, dAddr and dWData are held stable. mStall=!dAck.
- dAck==1 in ACCESS: at the edge, state goes to IDLE and dReq=0.
  - Load: wValid=1, wRdEnable=1, wRd=captured Rd, wResult=dRData.
  - Store: wValid=1, wRdEnable=0, wResult=stored data.
- Load with dAck in the first ACCESS cycle has total latency 2 cycles. Each extra wait cycle adds 1.
- dAck in IDLE is ignored.
- Once issued, a request is never cancelled except by reset. The EM latch is frozen during ACCESS, so mFlush is not re-evaluated mid-access.
- The next instruction is sampled in IDLE on the cycle after completion, because the EM latch advances on the completion edge.
- wValid, wRdEnable and mErr are 0 on any cycle that does not follow a retire or abort edge. wRd and wResult hold their last value.
- Back-to-back memory ops: each costs at least 2 cycles. IDLE lasts exactly one cycle between them.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on IDLE->ACCESS and increments each ACCESS cycle without dAck. It saturates; its width is sized for TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES with dAck==0, the next edge gives: state=IDLE, dReq=0, wValid=1, wRdEnable=0, mErr=1 for one cycle, mStall=0 in that final cycle.
  - dAck arriving in the same cycle as the limit wins: normal completion, mErr=0.
- Not defined: ACCESS waits indefinitely, mErr is tied to 0, and no counter logic is present.

Test Plan:
1. ALU op: mResult=0x12345678, mRd=3, mRdEnable=1 -> next cycle wValid=1, wRd=3, wResult=0x12345678; mStall never high.
2. Load: mAddr=0x00000106, mRd=5; dAck after 3 ACCESS cycles with dRData=0xCAFEBABE -> dAddr=0x00000104; mStall high 4 cycles; wResult=0xCAFEBABE, wRd=5 on retire.
3. Store: mAddr=0x40, mResult=0xDEADBEEF, mRdEnable=0; dAck in 1st ACCESS cycle -> dWe=1, dWData=0xDEADBEEF; wValid=1, wRdEnable=0.
4. Flush: mFlush=1, mAddrEnable=1 -> dReq stays 0, wValid=0, mStall=0.
5. Reset mid-ACCESS: rst=0 during the 2nd wait cycle -> next edge all outputs 0, state IDLE; a following ALU op retires normally.
6. MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4: load with no dAck -> dReq drops after 4 ACCESS cycles; mErr and wValid pulse 1, wRdEnable=0; dAck on cycle 4 instead -> normal retire, mErr=0.
